// File: rtl/reel_spin_ctrl.sv
// rtl/reel_spin_ctrl.sv - three-reel spin sequencer: scroll offsets, staggered random stops, result report
module reel_spin_ctrl #(
    parameter int unsigned SPEED          = 4,
    parameter int unsigned SPIN_FRAMES    = 90,
    parameter int unsigned STAGGER_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       spin_btn,
    output logic [8:0] reel0_off,
    output logic [8:0] reel1_off,
    output logic [8:0] reel2_off,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] sym0,
    output logic [1:0] sym1,
    output logic [1:0] sym2,
    output logic       win
);

    localparam logic [9:0]  STEP      = 10'(SPEED);
    localparam logic [15:0] SPIN_N    = 16'(SPIN_FRAMES);
    localparam logic [15:0] STAGGER_N = 16'(STAGGER_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_STAGGER,
        S_SETTLE,
        S_REPORT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic        btn_q;
    logic        btn_rise;
    logic [15:0] frame_cnt;
    logic [15:0] cnt_inc;
    logic [1:0]  idx;
    logic [2:0]  running;
    logic [2:0]  stopping;
    logic [1:0]  target [3];
    logic [8:0]  off [3];

    logic        start;
    logic [2:0]  stop_cmd;
    logic        enter_report;

    assign btn_rise = spin_btn & ~btn_q;
    assign cnt_inc  = frame_cnt + 16'd1;

    function automatic logic [8:0] adv_off(input logic [8:0] o);
        logic [9:0] s;
        s = {1'b0, o} + STEP;
        if (s >= 10'd480)
            s = s - 10'd480;
        return s[8:0];
    endfunction

    function automatic logic [8:0] aligned_off(input logic [1:0] t);
        case (t)
            2'd0:    return 9'd0;
            2'd1:    return 9'd120;
            2'd2:    return 9'd240;
            default: return 9'd360;
        endcase
    endfunction

    function automatic logic [1:0] sym_of(input logic [8:0] o);
        if (o >= 9'd360)      return 2'd3;
        else if (o >= 9'd240) return 2'd2;
        else if (o >= 9'd120) return 2'd1;
        else                  return 2'd0;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (btn_rise) state_nxt = S_SPIN;
            S_SPIN:    if (frame_tick && cnt_inc == SPIN_N) state_nxt = S_STAGGER;
            S_STAGGER: if (frame_tick && cnt_inc == STAGGER_N && idx == 2'd2) state_nxt = S_SETTLE;
            S_SETTLE:  if (running == 3'b000) state_nxt = S_REPORT;
            S_REPORT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start        = 1'b0;
        stop_cmd     = 3'b000;
        enter_report = 1'b0;
        case (state)
            S_IDLE:    start = btn_rise;
            S_SPIN:    stop_cmd[0] = frame_tick && (cnt_inc == SPIN_N);
            S_STAGGER: if (frame_tick && cnt_inc == STAGGER_N) stop_cmd = 3'b001 << idx;
            S_SETTLE:  enter_report = (running == 3'b000);
            default:   ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr  <= LFSR_SEED;
            btn_q <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn_q <= spin_btn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_cnt <= 16'd0;
            idx       <= 2'd0;
        end else if (start) begin
            frame_cnt <= 16'd0;
            idx       <= 2'd0;
        end else if ((state == S_SPIN || state == S_STAGGER) && frame_tick) begin
            frame_cnt <= (stop_cmd != 3'b000) ? 16'd0 : cnt_inc;
            if (state == S_SPIN && stop_cmd[0])
                idx <= 2'd1;
            else if (state == S_STAGGER && stop_cmd != 3'b000 && idx != 2'd2)
                idx <= idx + 2'd1;
        end
    end

    // The target check uses the stopping flag from before this edge, so the
    // tick that delivers a stop command still advances the reel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            running  <= 3'b000;
            stopping <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                off[i]    <= 9'd0;
                target[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (start) begin
                    running[i]  <= 1'b1;
                    stopping[i] <= 1'b0;
                end else begin
                    if (frame_tick && running[i]) begin
                        if (stopping[i] && off[i] == aligned_off(target[i]))
                            running[i] <= 1'b0;
                        else
                            off[i] <= adv_off(off[i]);
                    end
                    if (stop_cmd[i]) begin
                        stopping[i] <= 1'b1;
                        target[i]   <= lfsr[1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            sym0         <= 2'd0;
            sym1         <= 2'd0;
            sym2         <= 2'd0;
            win          <= 1'b0;
        end else begin
            result_valid <= enter_report;
            if (start)
                busy <= 1'b1;
            else if (enter_report)
                busy <= 1'b0;
            if (enter_report) begin
                sym0 <= sym_of(off[0]);
                sym1 <= sym_of(off[1]);
                sym2 <= sym_of(off[2]);
                win  <= (sym_of(off[0]) == sym_of(off[1])) && (sym_of(off[1]) == sym_of(off[2]));
            end
        end
    end

    assign reel0_off = off[0];
    assign reel1_off = off[1];
    assign reel2_off = off[2];

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// tb/tb_reel_spin_ctrl.sv - directed bench for reel_spin_ctrl
module tb_reel_spin_ctrl;

    localparam int          SPEED   = 40;
    localparam int          SPIN_N  = 15;
    localparam int          STAG_N  = 2;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       frame_tick = 1'b0;
    logic       spin_btn = 1'b0;
    logic [8:0] reel0_off, reel1_off, reel2_off;
    logic       busy, result_valid, win;
    logic [1:0] sym0, sym1, sym2;

    reel_spin_ctrl #(
        .SPEED(SPEED), .SPIN_FRAMES(SPIN_N), .STAGGER_FRAMES(STAG_N), .LFSR_SEED(SEED)
    ) dut (
        .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .spin_btn(spin_btn),
        .reel0_off(reel0_off), .reel1_off(reel1_off), .reel2_off(reel2_off),
        .busy(busy), .result_valid(result_valid),
        .sym0(sym0), .sym1(sym1), .sym2(sym2), .win(win)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass = 0;
    int         rv_count = 0;
    logic [15:0] m_lfsr;
    logic [8:0] offs [3];
    logic [1:0] syms [3];
    int         exp_off [3];
    int         tgt [3];

    assign offs[0] = reel0_off;
    assign offs[1] = reel1_off;
    assign offs[2] = reel2_off;
    assign syms[0] = sym0;
    assign syms[1] = sym1;
    assign syms[2] = sym2;

    // Reference LFSR: Fibonacci, taps 16,14,13,11, stepping every clock.
    always @(posedge CLK) begin
        if (RST)
            m_lfsr <= SEED;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(negedge CLK) begin
        if (result_valid)
            rv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic t, input logic b);
        frame_tick = t;
        spin_btn   = b;
        @(negedge CLK);
    endtask

    task automatic full_spin(input bit first, input bit reset_in_stagger);
        int need;
        int rv_before;
        bit got;
        check("busy_before_press", busy, 0);
        cyc(0, 0);
        cyc(0, 1);
        check("busy_after_press", busy, 1);
        for (int k = 1; k <= SPIN_N; k++) begin
            if (k == SPIN_N && first) begin
                need = ((exp_off[0] + SPEED) % 480) / 120;
                for (int w = 0; w < 200 && int'(m_lfsr[1:0]) != need; w++)
                    cyc(0, 1);
                check("align_lfsr_found", m_lfsr[1:0], need);
            end
            if (k == SPIN_N)
                tgt[0] = int'(m_lfsr[1:0]);
            cyc(1, 1);
            for (int i = 0; i < 3; i++)
                exp_off[i] = (exp_off[i] + SPEED) % 480;
            check($sformatf("spin_off0_t%0d", k), reel0_off, exp_off[0]);
            if (first && k == 11)
                check("off0_tick11", reel0_off, 440);
            if (first && k == 12)
                check("off2_tick12_wrap", reel2_off, 0);
        end
        check("spin_off1", reel1_off, exp_off[1]);
        check("spin_off2", reel2_off, exp_off[2]);
        for (int s = 1; s <= 2 * STAG_N; s++) begin
            cyc(0, 0);
            cyc(0, 1);
            if (s == STAG_N)
                tgt[1] = int'(m_lfsr[1:0]);
            if (s == 2 * STAG_N)
                tgt[2] = int'(m_lfsr[1:0]);
            cyc(1, 1);
            check($sformatf("stag_busy_s%0d", s), busy, 1);
            if (first && s == 1) begin
                check("aligned_reel0_no_move", reel0_off, 120);
                check("stag_off1_moves", reel1_off, 160);
            end
            if (reset_in_stagger && s == 1) begin
                rv_before = rv_count;
                RST = 1'b1;
                cyc(0, 0);
                RST = 1'b0;
                check("rst_off0", reel0_off, 0);
                check("rst_off1", reel1_off, 0);
                check("rst_off2", reel2_off, 0);
                check("rst_busy", busy, 0);
                check("rst_rv", result_valid, 0);
                for (int w = 0; w < 40; w++)
                    cyc(w % 2 == 0, 0);
                check("rst_no_result", rv_count, rv_before);
                check("rst_offs_idle", reel0_off, 0);
                for (int i = 0; i < 3; i++)
                    exp_off[i] = 0;
                return;
            end
        end
        rv_before = rv_count;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            cyc(c % 2 == 0, 1);
            if (result_valid)
                got = 1;
        end
        check("result_seen", got, 1);
        check("busy_falls_with_rv", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("final_off%0d", i), offs[i], tgt[i] * 120);
            check($sformatf("sym%0d", i), syms[i], tgt[i]);
        end
        check("win", win, (tgt[0] == tgt[1]) && (tgt[1] == tgt[2]));
        cyc(0, 1);
        check("rv_one_cycle", result_valid, 0);
        check("rv_pulse_count", rv_count, rv_before + 1);
        for (int i = 0; i < 3; i++)
            exp_off[i] = tgt[i] * 120;
        for (int w = 0; w < 3; w++)
            cyc(1, 1);
        check("held_btn_no_start", busy, 0);
        check("held_btn_off0_still", reel0_off, exp_off[0]);
        check("sym_held", sym0, tgt[0]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            exp_off[i] = 0;
        RST = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        RST = 1'b0;
        check("reset_off0", reel0_off, 0);
        check("reset_off1", reel1_off, 0);
        check("reset_off2", reel2_off, 0);
        check("reset_busy", busy, 0);
        check("reset_rv", result_valid, 0);
        check("reset_sym", {sym0, sym1, sym2}, 0);
        check("reset_win", win, 0);
        for (int t = 0; t < 100; t++)
            cyc(1, 0);
        check("idle_off0", reel0_off, 0);
        check("idle_off1", reel1_off, 0);
        check("idle_off2", reel2_off, 0);
        check("idle_busy", busy, 0);
        check("idle_no_rv", rv_count, 0);

        full_spin(1, 0);
        full_spin(0, 1);
        full_spin(0, 0);
        check("total_rv", rv_count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
